// File: rtl/div16.sv
// -----------------------------------------------------------------------------
// div16 - multi-cycle unsigned 16-bit restoring divider (plus its alu16).
//
// The divider runs one restoring step per clock through a single alu16
// configured for subtraction (A + ~B + 1). A start in IDLE captures the
// operands; 16 RUN cycles later a one-cycle done pulse marks valid results.
// A zero divisor skips RUN and reports DBZ_QUOTIENT / dividend immediately.
//
// alu16 ports:
//   a, b      in  16  operands
//   ctrl      in  3   000 AND, 001 OR, 010 ADD, 011 SUB (a + ~b + c_in), 100 XOR
//   c_in      in  1   carry in
//   y         out 16  result
//   c_out     out 1   carry out (for SUB with c_in=1: 1 means a >= b)
//
// div16 ports:
//   clk       in  1   clock, rising edge
//   reset     in  1   asynchronous active-high reset
//   start     in  1   divide request, accepted only in IDLE
//   dividend  in  16  numerator, captured on accept
//   divisor   in  16  denominator, captured on accept
//   busy      out 1   high while in RUN
//   done      out 1   one-cycle pulse, results valid from this cycle on
//   quotient  out 16  registered quotient
//   remainder out 16  registered remainder
//   divByZero out 1   registered divide-by-zero flag
// -----------------------------------------------------------------------------

module alu16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  ctrl,
    input  logic        c_in,
    output logic [15:0] y,
    output logic        c_out
);

    logic [16:0] sum_s;

    // Operation select; bit 16 of sum_s carries out of the arithmetic ops.
    always_comb begin
        sum_s = {1'b0, a};
        case (ctrl)
            3'b000:  sum_s = {1'b0, a & b};
            3'b001:  sum_s = {1'b0, a | b};
            3'b010:  sum_s = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};
            3'b011:  sum_s = {1'b0, a} + {1'b0, ~b} + {16'h0000, c_in};
            3'b100:  sum_s = {1'b0, a ^ b};
            default: sum_s = {1'b0, a};
        endcase
    end

    assign y     = sum_s[15:0];
    assign c_out = sum_s[16];

endmodule

module div16 #(
    parameter logic [15:0] DBZ_QUOTIENT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        divByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r, state_n;
    logic [3:0]  count_r, count_n;
    logic [15:0] d_r, d_n;
    logic [15:0] q_r, q_n;
    logic [15:0] r_r, r_n;
    logic [15:0] quot_n, rem_n;
    logic        dbz_n, busy_n, done_n;

    logic [16:0] s_s;
    logic [15:0] alu_y_s;
    logic        alu_cout_s;
    logic        take_s;
    logic [15:0] q_step_s;
    logic [15:0] r_step_s;

    // {R,Q} shifted left by one: R gains Q's MSB and keeps its old MSB as bit 16,
    // which matters whenever the partial remainder is already >= 16'h8000.
    assign s_s = {r_r, q_r[15]};

    alu16 u_alu (
        .a     (s_s[15:0]),
        .b     (d_r),
        .ctrl  (3'b011),
        .c_in  (1'b1),
        .y     (alu_y_s),
        .c_out (alu_cout_s)
    );

    // S >= D when either the 17th bit is set or the 16-bit subtract did not borrow.
    assign take_s   = s_s[16] | alu_cout_s;
    assign q_step_s = {q_r[14:0], take_s};
    assign r_step_s = take_s ? alu_y_s : s_s[15:0];

    // Next-state, datapath and output decode.
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        d_n     = d_r;
        q_n     = q_r;
        r_n     = r_r;
        quot_n  = quotient;
        rem_n   = remainder;
        dbz_n   = divByZero;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor != 16'h0000) begin
                        d_n     = divisor;
                        q_n     = dividend;
                        r_n     = 16'h0000;
                        count_n = 4'd0;
                        state_n = RUN;
                    end else begin
                        quot_n  = DBZ_QUOTIENT;
                        rem_n   = dividend;
                        dbz_n   = 1'b1;
                        state_n = DONE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                q_n     = q_step_s;
                r_n     = r_step_s;
                count_n = count_r + 4'd1;
                if (count_r == 4'd15) begin
                    quot_n  = q_step_s;
                    rem_n   = r_step_s;
                    dbz_n   = 1'b0;
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= 4'd0;
            d_r       <= 16'h0000;
            q_r       <= 16'h0000;
            r_r       <= 16'h0000;
            quotient  <= 16'h0000;
            remainder <= 16'h0000;
            divByZero <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            d_r       <= d_n;
            q_r       <= q_n;
            r_r       <= r_n;
            quotient  <= quot_n;
            remainder <= rem_n;
            divByZero <= dbz_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_div16.sv
module tb_div16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        divByZero;

    int n_checks = 0;
    int n_pass   = 0;

    div16 #(.DBZ_QUOTIENT(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issue one start at the next edge, wait for done and check results/timing.
    task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                           input logic [15:0] exp_q, input logic [15:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'h1234;
        divisor  = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_cycles, (exp_lat == 1) ? 0 : 16);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " divByZero"}, divByZero, exp_dbz);
        @(negedge clk);
        check({tag, " done_pulse_end"}, done, 1'b0);
    endtask

    initial begin
        int saw_done;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;
        #12;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 16'h0000);
        check("reset remainder", remainder, 16'h0000);
        check("reset dbz", divByZero, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        run_div("FFFF/1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_div("8000/FFFF", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17);
        run_div("3/10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
        run_div("FFFF/8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17);
        run_div("5/0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
        run_div("9/3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

        // Start pulses during RUN and in the DONE cycle must be ignored.
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                dividend = 16'd50;
                divisor  = 16'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                saw_done = i;
                dividend = 16'd50;
                divisor  = 16'd5;
                start    = 1'b1;
                break;
            end
        end
        check("ignore latency", saw_done, 17);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ignore busy_after_done", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2) begin
                check("hold idle", {done, busy, quotient[13:0]}, {1'b0, 1'b0, 14'd14});
            end
        end
        check("hold quotient", quotient, 16'd14);
        check("hold remainder", remainder, 16'd2);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("midrun busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort quotient", quotient, 16'h0000);
        check("abort remainder", remainder, 16'h0000);
        check("abort done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort no_done", saw_done, 0);
        run_div("1000/3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div16.md
Name: div16

Overview:
- Multi-cycle unsigned 16-bit restoring divider.
- It is the sequencing counterpart of alu16: it instantiates one alu16 in subtract mode and drives its operands over 16 iterations to compute quotient and remainder.
- It sits beside the datapath ALU and serves divide instructions through a start/done handshake.

Parameters:
- DBZ_QUOTIENT, 16'hFFFF, quotient value reported on divide-by-zero.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a divide; sampled on the clk edge, accepted only in IDLE.
- dividend  input  16  unsigned numerator; captured when start is accepted.
- divisor  input  16  unsigned denominator; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  16  registered result.
- remainder  output  16  registered result.
- divByZero  output  1  registered flag; set with done when divisor was 0.

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, divByZero = 0; quotient, remainder = 16'h0000; iteration count = 0.
- Reset asserted mid-operation aborts the divide with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - Capture divisor into D and dividend into Q.
  - R=0, count=0, go to RUN.
- IDLE, start=1, divisor==0:
  - Go to DONE with quotient=DBZ_QUOTIENT, remainder=dividend, divByZero=1.
  - Latency is 1 edge.
- RUN, one restoring step per cycle:
  - Shift {R,Q} left 1; S = shifted R (17 bits).
  - alu16 gets A=S[15:0], B=D, ctrl=3'b011, cIn=1.
  - Take the subtraction if S[16] | alu cOut.
  - If taken: R=aluOut, Q[0]=1. Otherwise: R=S[15:0], Q[0]=0.
  - count increments each step. After the 16th step (count==15), load quotient=Q and remainder=R, set divByZero=0, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. Output registers hold.
- Latency: start accepted at edge 0; RUN occupies edges 1..16; done is high in the cycle after edge 16.
- busy is high only in RUN.
- start in RUN or DONE is ignored. Operand inputs may change freely after capture.
- quotient, remainder and divByZero hold their last values until the next accepted start completes. They do not clear on accept.
- Arithmetic:
  - Unsigned only; no signed mode.
  - Result invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
  - The 17th bit S[16] is mandatory; it covers remainders at or above 16'h8000.
- The only arithmetic unit is the single alu16 instance; no "/" or "%" operators.

Test Plan:
- dividend=100, divisor=7, start one cycle -> busy 16 cycles; done pulse 17 cycles after start edge; quotient=14, remainder=2, divByZero=0.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0. Then dividend=16'h8000, divisor=16'hFFFF -> quotient=0, remainder=16'h8000 (exercises S[16]).
- dividend=3, divisor=10 -> quotient=0, remainder=3. Then dividend=16'hFFFF, divisor=16'h8001 -> quotient=1, remainder=16'h7FFE.
- dividend=5, divisor=0 -> done one cycle after start; quotient=16'hFFFF, remainder=5, divByZero=1; busy never asserts. A following 9/3 -> quotient=3, remainder=0, divByZero=0.
- start 100/7 and pulse start with 50/5 during RUN and in the DONE cycle -> second request ignored; result 14/2. Results hold unchanged over 5 idle cycles.
- start 1000/3, assert reset at RUN cycle 8 -> outputs go to 0 immediately, no done pulse. After release, 1000/3 -> quotient=333, remainder=1.
